// File: rtl/axi_read_slave_burst.sv
// AXI4 read slave with FIXED/INCR/WRAP bursts, fixed-latency memory port and an R-data FIFO.
// Optional address decode with DECERR responses: define AXI_RD_DECERR_EN.
module axi_read_slave_burst #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          ID_WIDTH    = 4,
  parameter int          MEM_LATENCY = 1,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE    = 32'h0001_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic [ID_WIDTH-1:0]   arid,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic [ID_WIDTH-1:0]   rid,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int LG = $clog2(DATA_WIDTH/8);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1) + 1;
  localparam logic [ADDR_WIDTH-1:0] LANE = ADDR_WIDTH'((1 << LG) - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                state_q;
  logic                  arready_q, err_q, mem_req_q;
  logic [ADDR_WIDTH-1:0] addr_q, mem_addr_q;
  logic [7:0]            len_q, cnt_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [ID_WIDTH-1:0]   id_q;

  // Beat tags travel alongside the memory pipe so error beats keep their order.
  logic [MEM_LATENCY:0]  pv_q, pm_q, pl_q;
  logic [1:0]            pr_q [MEM_LATENCY+1];

  logic [DATA_WIDTH-1:0] fd_q [FIFO_DEPTH];
  logic [1:0]            fr_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fl_q;
  logic [PW-1:0]         rp_q, wp_q;
  logic [CW-1:0]         count_q, infl_q;

  logic                  pop, push, issue, credit_ok, ar_err, decerr, beat_mem, beat_last;
  logic [1:0]            beat_resp;
  logic [ADDR_WIDTH-1:0] step_d, wrap_mask_d, addr_d;

  assign rvalid = (count_q != '0);
  assign pop    = rvalid & rready;
  assign push   = pv_q[MEM_LATENCY];

  // A slot freed by this cycle's pop can be reused: the new beat lands at least one edge later.
  assign credit_ok = ({1'b0, count_q} + {1'b0, infl_q}) < ((CW+1)'(FIFO_DEPTH) + (CW+1)'(pop));
  assign issue     = (state_q == S_ISSUE) && credit_ok;
  assign beat_last = (cnt_q == len_q);

  assign ar_err = (arsize > 3'(LG)) || (arburst == 2'b11) ||
                  ((arburst == 2'b10) && !((arlen == 8'd1) || (arlen == 8'd3) ||
                                           (arlen == 8'd7) || (arlen == 8'd15)));

`ifdef AXI_RD_DECERR_EN
  logic [ADDR_WIDTH-1:0] offset_d;
  assign offset_d = addr_q - ADDR_WIDTH'(MEM_BASE);
  assign decerr   = !(offset_d < ADDR_WIDTH'(MEM_SIZE));
`else
  logic unused_cfg;
  assign unused_cfg = ^{MEM_BASE, MEM_SIZE};
  assign decerr     = 1'b0;
`endif

  assign beat_resp = err_q ? 2'b10 : (decerr ? 2'b11 : 2'b00);
  assign beat_mem  = (beat_resp == 2'b00);

  always_comb begin
    step_d      = ADDR_WIDTH'(1) << size_q;
    wrap_mask_d = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    case (burst_q)
      2'b00:   addr_d = addr_q;
      2'b10:   addr_d = (addr_q & ~wrap_mask_d) | ((addr_q + step_d) & wrap_mask_d);
      default: addr_d = addr_q + step_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      arready_q  <= 1'b0;
      err_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      id_q       <= '0;
    end else begin
      mem_req_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arvalid && arready_q) begin
            addr_q    <= araddr;
            len_q     <= arlen;
            size_q    <= arsize;
            burst_q   <= arburst;
            id_q      <= arid;
            err_q     <= ar_err;
            cnt_q     <= '0;
            arready_q <= 1'b0;
            state_q   <= S_ISSUE;
          end else begin
            arready_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (issue) begin
            mem_req_q  <= beat_mem;
            mem_addr_q <= addr_q & ~LANE;
            addr_q     <= addr_d;
            if (beat_last) state_q <= S_DRAIN;
            else           cnt_q   <= cnt_q + 8'd1;
          end
        end
        S_DRAIN: begin
          if (pop && rlast) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q    <= '0;
      pm_q    <= '0;
      pl_q    <= '0;
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
      infl_q  <= '0;
      for (int unsigned i = 0; i < MEM_LATENCY+1; i++) pr_q[i] <= '0;
    end else begin
      pv_q    <= {pv_q[MEM_LATENCY-1:0], issue};
      pm_q    <= {pm_q[MEM_LATENCY-1:0], beat_mem};
      pl_q    <= {pl_q[MEM_LATENCY-1:0], beat_last};
      pr_q[0] <= beat_resp;
      for (int unsigned i = 1; i < MEM_LATENCY+1; i++) pr_q[i] <= pr_q[i-1];

      case ({issue, push})
        2'b10:   infl_q <= infl_q + CW'(1);
        2'b01:   infl_q <= infl_q - CW'(1);
        default: infl_q <= infl_q;
      endcase

      if (push) begin
        fd_q[wp_q] <= pm_q[MEM_LATENCY] ? mem_rdata : '0;
        fr_q[wp_q] <= pr_q[MEM_LATENCY];
        fl_q[wp_q] <= pl_q[MEM_LATENCY];
        wp_q       <= wp_q + PW'(1);
      end
      if (pop) rp_q <= rp_q + PW'(1);

      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign arready  = arready_q;
  assign rdata    = rvalid ? fd_q[rp_q] : '0;
  assign rresp    = rvalid ? fr_q[rp_q] : 2'b00;
  assign rlast    = rvalid ? fl_q[rp_q] : 1'b0;
  assign rid      = id_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_axi_read_slave_burst.sv
// Scoreboard bench for axi_read_slave_burst: stimulus pushes expected beats/addresses, a monitor checks them.
module tb_axi_read_slave_burst;
  localparam int AW = 32, DW = 32, IW = 4, FD = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          arvalid = 1'b0, arready;
  logic [AW-1:0] araddr = '0;
  logic [7:0]    arlen = '0;
  logic [2:0]    arsize = '0;
  logic [1:0]    arburst = '0;
  logic [IW-1:0] arid = '0;
  logic          rvalid, rready = 1'b1, rlast, mem_req;
  logic [DW-1:0] rdata, mem_rdata = '0;
  logic [1:0]    rresp;
  logic [IW-1:0] rid;
  logic [AW-1:0] mem_addr;

  axi_read_slave_burst #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_LATENCY(1),
    .FIFO_DEPTH(FD), .MEM_BASE(32'h0), .MEM_SIZE(32'h1000)
  ) dut (
    .clk(clk), .rst(rst), .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rid(rid), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  // One-cycle-latency memory model.
  always @(posedge clk) if (mem_req) mem_rdata <= f(mem_addr);

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] addr_exp_q[$];
  int checks = 0, passes = 0, beats_seen = 0, mreq_tot = 0, okay_tot = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic exp_beat(input logic [31:0] d, input logic [1:0] r, input logic l, input logic [3:0] id);
    beat_t b;
    b.data = d; b.resp = r; b.last = l; b.id = id;
    exp_q.push_back(b);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      addr_exp_q.delete();
      mreq_tot = 0;
      okay_tot = 0;
    end else begin
      if (mem_req) begin
        mreq_tot++;
        if (addr_exp_q.size() == 0) chk("mem_req_unexpected", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("mem_addr", 64'(mem_addr), 64'(addr_exp_q.pop_front()));
        chk("credit_bound", 64'((mreq_tot - okay_tot) <= FD), 64'd1);
      end
      if (rvalid && rready) begin
        beats_seen++;
        if (rresp == 2'b00) okay_tot++;
        if (exp_q.size() == 0) chk("beat_unexpected", 64'(rdata), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("rdata", 64'(rdata), 64'(b.data));
          chk("rresp", 64'(rresp), 64'(b.resp));
          chk("rlast", 64'(rlast), 64'(b.last));
          chk("rid",   64'(rid),   64'(b.id));
        end
      end
    end
  end

  task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] bu, input logic [3:0] id);
    int n;
    araddr = a; arlen = l; arsize = s; arburst = bu; arid = id; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!arready) chk("ar_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || addr_exp_q.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_rvalid",  64'(rvalid),  64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_rdata",   64'(rdata),   64'd0);
    chk("rst_rresp",   64'(rresp),   64'd0);
    chk("rst_rlast",   64'(rlast),   64'd0);
    chk("rst_rid",     64'(rid),     64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arready_after_rst", 64'(arready), 64'd1);

    // INCR 0x100, 4 beats
    for (int i = 0; i < 4; i++) begin
      addr_exp_q.push_back(32'h100 + 32'(i*4));
      exp_beat(f(32'h100 + 32'(i*4)), 2'b00, i == 3, 4'd5);
    end
    send_ar(32'h100, 8'd3, 3'd2, 2'b01, 4'd5);
    wait_idle(100);

    // WRAP 0x1C, 4 beats
    addr_exp_q.push_back(32'h1C); exp_beat(f(32'h1C), 2'b00, 1'b0, 4'd3);
    addr_exp_q.push_back(32'h10); exp_beat(f(32'h10), 2'b00, 1'b0, 4'd3);
    addr_exp_q.push_back(32'h14); exp_beat(f(32'h14), 2'b00, 1'b0, 4'd3);
    addr_exp_q.push_back(32'h18); exp_beat(f(32'h18), 2'b00, 1'b1, 4'd3);
    send_ar(32'h1C, 8'd3, 3'd2, 2'b10, 4'd3);
    wait_idle(100);

    // FIXED 0x40, 3 beats, rready pattern 1,0,0,1
    for (int i = 0; i < 3; i++) begin
      addr_exp_q.push_back(32'h40);
      exp_beat(f(32'h40), 2'b00, i == 2, 4'd7);
    end
    send_ar(32'h40, 8'd2, 3'd2, 2'b00, 4'd7);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      rready = ((i % 4) == 0) || ((i % 4) == 3);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    wait_idle(100);

    // arsize too large: SLVERR, no mem_req; then a normal INCR
    exp_beat(32'h0, 2'b10, 1'b0, 4'd2);
    exp_beat(32'h0, 2'b10, 1'b1, 4'd2);
    send_ar(32'h0, 8'd1, 3'd3, 2'b01, 4'd2);
    wait_idle(100);
    addr_exp_q.push_back(32'h80); exp_beat(f(32'h80), 2'b00, 1'b0, 4'd2);
    addr_exp_q.push_back(32'h84); exp_beat(f(32'h84), 2'b00, 1'b1, 4'd2);
    send_ar(32'h80, 8'd1, 3'd2, 2'b01, 4'd2);
    wait_idle(100);

    // reserved burst type, single beat
    exp_beat(32'h0, 2'b10, 1'b1, 4'd1);
    send_ar(32'h60, 8'd0, 3'd2, 2'b11, 4'd1);
    wait_idle(100);

    // WRAP with illegal length 3 beats
    for (int i = 0; i < 3; i++) exp_beat(32'h0, 2'b10, i == 2, 4'd4);
    send_ar(32'h60, 8'd2, 3'd2, 2'b10, 4'd4);
    wait_idle(100);

    // arlen=0 single beat
    addr_exp_q.push_back(32'h20); exp_beat(f(32'h20), 2'b00, 1'b1, 4'd6);
    send_ar(32'h20, 8'd0, 3'd2, 2'b01, 4'd6);
    wait_idle(100);

    // byte-size INCR from an unaligned address: mem_addr stays word aligned
    for (int i = 0; i < 3; i++) begin
      addr_exp_q.push_back(32'h100);
      exp_beat(f(32'h100), 2'b00, i == 2, 4'd8);
    end
    send_ar(32'h101, 8'd2, 3'd0, 2'b01, 4'd8);
    wait_idle(100);

    // reset after beat 2 of 8
    for (int i = 0; i < 8; i++) begin
      addr_exp_q.push_back(32'h200 + 32'(i*4));
      exp_beat(f(32'h200 + 32'(i*4)), 2'b00, i == 7, 4'd9);
    end
    base = beats_seen;
    send_ar(32'h200, 8'd7, 3'd2, 2'b01, 4'd9);
    for (int n = 0; n < 100 && beats_seen < base + 2; n++) @(negedge clk);
    chk("mid_burst_beats", 64'(beats_seen - base), 64'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    rready = 1'b0;
    @(posedge clk); #1;
    chk("midrst_rvalid",  64'(rvalid),  64'd0);
    chk("midrst_mem_req", 64'(mem_req), 64'd0);
    chk("midrst_arready", 64'(arready), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_arready_after", 64'(arready), 64'd1);
    rready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    addr_exp_q.push_back(32'h300); exp_beat(f(32'h300), 2'b00, 1'b0, 4'd10);
    addr_exp_q.push_back(32'h304); exp_beat(f(32'h304), 2'b00, 1'b1, 4'd10);
    send_ar(32'h300, 8'd1, 3'd2, 2'b01, 4'd10);
    wait_idle(100);

    // INCR across the decode limit
    addr_exp_q.push_back(32'hFF8); exp_beat(f(32'hFF8), 2'b00, 1'b0, 4'd11);
    addr_exp_q.push_back(32'hFFC); exp_beat(f(32'hFFC), 2'b00, 1'b0, 4'd11);
`ifdef AXI_RD_DECERR_EN
    exp_beat(32'h0, 2'b11, 1'b0, 4'd11);
    exp_beat(32'h0, 2'b11, 1'b1, 4'd11);
`else
    addr_exp_q.push_back(32'h1000); exp_beat(f(32'h1000), 2'b00, 1'b0, 4'd11);
    addr_exp_q.push_back(32'h1004); exp_beat(f(32'h1004), 2'b00, 1'b1, 4'd11);
`endif
    send_ar(32'hFF8, 8'd3, 3'd2, 2'b01, 4'd11);
    wait_idle(100);

    chk("beats_left",  64'(exp_q.size()),      64'd0);
    chk("addrs_left",  64'(addr_exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/axi_read_slave_burst.md
Name: axi_read_slave_burst

Overview:
- Parametrised AXI4 read slave; next generation of the single-ID, INCR-only read slave.
- Adds FIXED/INCR/WRAP bursts, configurable data/ID width, fixed-latency pipelined memory port and a credit-managed R-data FIFO that absorbs rready backpressure without stalling the memory pipe.
- Sits between the AXI interconnect and on-chip instruction/data RAM.

Parameters:
ADDR_WIDTH, 32, AXI/memory byte address width
DATA_WIDTH, 32, R data and memory word width; power of 2, 32..256
ID_WIDTH, 4, arid/rid width
MEM_LATENCY, 1, cycles from mem_req to mem_rdata valid; 1..4
FIFO_DEPTH, 4, R data FIFO entries; power of 2, >= MEM_LATENCY+1
MEM_BASE, 32'h0000_0000, decode base (used only with AXI_RD_DECERR_EN)
MEM_SIZE, 32'h0001_0000, decode size in bytes (used only with AXI_RD_DECERR_EN)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
arvalid  in  1  AR valid
arready  out  1  AR ready
araddr  in  ADDR_WIDTH  burst start byte address
arlen  in  8  beats-1
arsize  in  3  log2 bytes per beat
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
arid  in  ID_WIDTH  transaction ID
rvalid  out  1  R valid
rready  in  1  R ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
rlast  out  1  final beat
rid  out  ID_WIDTH  equals latched arid
mem_req  out  1  memory read strobe
mem_addr  out  ADDR_WIDTH  word-aligned byte address (low log2(DATA_WIDTH/8) bits zero)
mem_rdata  in  DATA_WIDTH  valid exactly MEM_LATENCY cycles after mem_req

Behaviour:
- Reset (rst=1 at clk edge): arready=0, rvalid=0, rlast=0, rresp=00, rid=0, rdata=0, mem_req=0, mem_addr=0; FIFO emptied, in-flight memory returns discarded, FSM->IDLE. Reset mid-burst aborts the burst with no further beats.
- FSM IDLE: arready=1. AR handshake (arvalid&arready) latches addr/len/size/burst/id; arready=0 next cycle; ->ISSUE.
- ISSUE: mem_req=1 when credits>0 (credits = FIFO_DEPTH - occupancy - in-flight). Issue counter 0..arlen; on last issue ->DRAIN.
- DRAIN: wait until final beat (rlast&rvalid&rready); ->IDLE; arready=1 in the following cycle (one bubble between bursts).
- Latency: first rvalid no earlier than MEM_LATENCY+2 cycles after AR handshake; sustained 1 beat/cycle with rready=1.
- Address generation per issued beat, step = 1<<arsize:
  - FIXED: constant start address.
  - INCR: addr+step, ADDR_WIDTH modular arithmetic; no 4 KB check.
  - WRAP: boundary = (arlen+1)*step; next = (addr & ~(boundary-1)) | ((addr+step) & (boundary-1)).
  - mem_addr = addr with low byte-lane bits cleared.
- R channel driven from FIFO head: rvalid = !empty; rdata/rresp/rlast stable while rvalid&!rready. rlast set on beat arlen. rid = latched arid on every beat.
- Error responses (no mem_req issued for the beat; rdata=0, beat still occupies FIFO slot in order):
  - arsize > log2(DATA_WIDTH/8): SLVERR for all beats.
  - arburst=11: SLVERR for all beats.
  - WRAP with arlen not in {1,3,7,15}: SLVERR for all beats.
- FIFO simultaneous push and pop when full-with-pop: allowed; occupancy unchanged. Credit check guarantees no overflow; overflow is a design bug (assertion).
- arlen=0: single beat, rlast=1 on first beat.
- arvalid while busy: ignored (arready=0); AR must hold until accepted.

Optional Feature:
- Macro AXI_RD_DECERR_EN.
- Defined: a beat whose address lies outside [MEM_BASE, MEM_BASE+MEM_SIZE) returns DECERR, rdata=0, no mem_req; evaluated per beat, so a burst crossing the limit mixes OKAY and DECERR beats.
- Undefined: no decode; all beats forwarded to memory (subject to SLVERR rules); MEM_BASE/MEM_SIZE unused.

Test Plan:
- INCR, araddr=0x100, arlen=3, arsize=2, rready=1, MEM_LATENCY=1 -> mem_addr 0x100,0x104,0x108,0x10C; 4 beats OKAY; rlast only on beat 4; rid=arid.
- WRAP, araddr=0x1C, arlen=3, arsize=2 -> mem_addr 0x1C,0x10,0x14,0x18.
- FIXED, arlen=2 at 0x40 with rready toggling 1,0,0,1,... -> 3 beats all from 0x40; data held stable during stalls; mem_req count never exceeds FIFO_DEPTH ahead of consumed beats.
- arsize=3 with DATA_WIDTH=32, arlen=1 -> 2 beats SLVERR, rdata=0, no mem_req; then INCR burst accepted normally.
- rst asserted mid-burst after beat 2 of 8 -> next cycle rvalid=0, mem_req=0, arready=0; arready=1 the cycle after rst deasserts; no stale beat emitted.
- With AXI_RD_DECERR_EN, MEM_SIZE=0x1000: INCR at 0xFF8, arlen=3 -> beats OKAY, OKAY, DECERR, DECERR; without the macro -> all OKAY.
